gpio_cell_bank: RTL

GPIO_CELL_BANK -- requirements
Module: gpio_cell_bank

---
 rtl/gpio_cell_bank.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gpio_cell_bank.sv
// -----------------------------------------------------------------------------
// gpio_cell_bank
//
// A bank of N bidirectional GPIO cells. Each channel has:
//   - a combinational tri-state output driver (pad = oe ? o : Z),
//   - a SYNC_STAGES-deep input synchronizer that always samples the pad,
//   - a glitch filter that only accepts a new level once it has been seen
//     for FILTER_CYCLES consecutive cycles (FILTER_CYCLES = 0 bypasses it),
//   - rising/falling edge detection on the filtered level feeding a sticky
//     pending bit with a one-cycle clear strobe (set wins over clear).
//
// Ports:
//   clock     in   single clock, all state on its rising edge
//   reset_n   in   asynchronous active-low reset
//   pad       io   [N] external pins
//   o         in   [N] core output data
//   oe        in   [N] per-pin output enable
//   ie        in   [N] per-pin input enable (gates i and event capture)
//   i         out  [N] filtered input data, forced to 0 where ie = 0
//   rise_en   in   [N] rising-edge event enable
//   fall_en   in   [N] falling-edge event enable
//   pend_clr  in   [N] one-cycle clear strobes for pend
//   pend      out  [N] sticky edge-event pending bits
//   irq       out  OR of all pend bits
// -----------------------------------------------------------------------------
module gpio_cell_bank #(
   parameter int N             = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   inout  wire  [N-1:0] pad,
   input  logic [N-1:0] o,
   input  logic [N-1:0] oe,
   input  logic [N-1:0] ie,
   output logic [N-1:0] i,
   input  logic [N-1:0] rise_en,
   input  logic [N-1:0] fall_en,
   input  logic [N-1:0] pend_clr,
   output logic [N-1:0] pend,
   output logic         irq
);

   // Counter width; kept at least 1 so the declaration stays legal when the
   // filter is bypassed (no counters are generated in that case).
   localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

   genvar gi;

   // -------------------------------------------------------------------------
   // Output drivers: purely combinational, independent of reset.
   // -------------------------------------------------------------------------
   generate
      for (gi = 0; gi < N; gi++) begin : g_pad
         assign pad[gi] = oe[gi] ? o[gi] : 1'bz;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Input synchronizer. The resolved pin level is sampled every cycle,
   // whether the pin is being driven by us or from outside, and whatever ie is.
   // -------------------------------------------------------------------------
   logic [N-1:0] sync_reg [SYNC_STAGES];
   logic [N-1:0] sync;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= '0;
         end
      end else begin
         sync_reg[0] <= pad;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= sync_reg[s-1];
         end
      end
   end

   assign sync = sync_reg[SYNC_STAGES-1];

   // -------------------------------------------------------------------------
   // Glitch filter. The counter measures how long sync has disagreed with
   // filt; any agreement restarts it, so short pulses leave filt untouched.
   // Loading on count == FILTER_CYCLES-1 means the new level is accepted on
   // the FILTER_CYCLES-th consecutive disagreeing edge.
   // -------------------------------------------------------------------------
   logic [N-1:0] filt;

   generate
      if (FILTER_CYCLES == 0) begin : g_nofilt
         assign filt = sync;
      end else begin : g_filt
         for (gi = 0; gi < N; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          filt_reg;
            logic          filt_next;

            always_comb begin
               cnt_next  = cnt_reg;
               filt_next = filt_reg;
               if (sync[gi] == filt_reg) begin
                  cnt_next = '0;
               end else if (cnt_reg == CW'(FILTER_CYCLES - 1)) begin
                  filt_next = sync[gi];
                  cnt_next  = '0;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end

            always_ff @(posedge clock or negedge reset_n) begin
               if (!reset_n) begin
                  cnt_reg  <= '0;
                  filt_reg <= 1'b0;
               end else begin
                  cnt_reg  <= cnt_next;
                  filt_reg <= filt_next;
               end
            end

            assign filt[gi] = filt_reg;
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Edge detection and sticky pending bits. prev resets to 0 alongside filt,
   // so coming out of reset with filt still 0 produces no spurious event.
   // -------------------------------------------------------------------------
   logic [N-1:0] prev_reg;
   logic [N-1:0] pend_reg;
   logic [N-1:0] pend_next;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] pend_set;

   always_comb begin
      rise      = filt & ~prev_reg;
      fall      = ~filt & prev_reg;
      pend_set  = ie & ((rise & rise_en) | (fall & fall_en));
      // Set is OR-ed in after the clear so a coincident event wins.
      pend_next = (pend_reg & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_reg <= '0;
         pend_reg <= '0;
      end else begin
         prev_reg <= filt;
         pend_reg <= pend_next;
      end
   end

   assign i    = ie & filt;
   assign pend = pend_reg;
   assign irq  = |pend_reg;

endmodule
